// File: rtl/mips_rf_pkg.sv
// Shared register-file types and the write-port priority helper used by
// regfile_mp and rf_scoreboard.
package mips_rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  // Upper bound on write ports; the hit vectors below are sized to it.
  localparam int MAX_WR     = 8;
  localparam int WR_IDX_W   = 3;

  typedef logic [DATA_W_DEF-1:0] reg_data_t;
  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  typedef struct packed {
    logic                valid;
    logic [WR_IDX_W-1:0] idx;
  } wr_sel_t;

  // hit[i] = write port i is enabled and targets the address of interest.
  // The highest-index hit wins, so a later iteration overrides an earlier one.
  function automatic wr_sel_t wr_winner(input logic [MAX_WR-1:0] hit);
    wr_sel_t sel;
    sel = '0;
    for (int i = 0; i < MAX_WR; i++) begin
      if (hit[i]) begin
        sel.valid = 1'b1;
        sel.idx   = WR_IDX_W'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: issue marks a register busy, writeback clears
// it, flush clears everything. busy_any is the OR of the registered bits.
module rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  output logic [(2**ADDR_W)-1:0]   busy,
  output logic                     busy_any
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] busy_q;

  // Later assignments take precedence: write clear < issue set < flush.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p]) begin
        busy_d[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (issue_en) begin
      busy_d[issue_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
    if (flush) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign busy_any = |busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-collision priority and busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
  import mips_rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush,
  output logic                     busy_any
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy;

  function automatic logic [MAX_WR-1:0] wr_hits(
    input logic [ADDR_W-1:0]        a,
    input logic [NUM_WR-1:0]        en,
    input logic [NUM_WR*ADDR_W-1:0] addrs
  );
    logic [MAX_WR-1:0] h;
    h = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      h[p] = en[p] && (addrs[p*ADDR_W +: ADDR_W] == a);
    end
    return h;
  endfunction

  always_comb begin
    mem_d = mem_q;
    for (int r = 0; r < DEPTH; r++) begin
      wr_sel_t sel;
      sel = wr_winner(wr_hits(ADDR_W'(r), wr_en, wr_addr));
      if (sel.valid && !(ZERO_REG != 0 && r == 0)) begin
        mem_d[r] = wr_data[int'(sel.idx)*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy),
    .busy_any   (busy_any)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] ra;
      ra = rd_addr[i*ADDR_W +: ADDR_W];
      rd_data[i*DATA_W +: DATA_W] = mem_q[ra];
      rd_busy[i]                  = busy[ra];
`ifdef REGFILE_BYPASS_EN
      begin
        wr_sel_t rsel;
        rsel = wr_winner(wr_hits(ra, wr_en, wr_addr));
        // Forwarding is suppressed while reset is held so outputs read zero.
        if (rsel.valid && reset) begin
          rd_data[i*DATA_W +: DATA_W] = wr_data[int'(rsel.idx)*DATA_W +: DATA_W];
          rd_busy[i]                  = 1'b0;
        end
      end
`endif
      if (ZERO_REG != 0 && ra == '0) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
        rd_busy[i]                  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (default parameters); expectations follow
// REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic              clk;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              issue_en;
  logic [AW-1:0]     issue_addr;
  logic              flush;
  logic              busy_any;

  int n_checks;
  int n_pass;

  regfile_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .NUM_WR   (NW),
    .ZERO_REG (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .flush      (flush),
    .busy_any   (busy_any)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = '0;
    issue_en = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic set_issue(input logic [AW-1:0] a);
    issue_en   = 1'b1;
    issue_addr = a;
  endtask

  function automatic logic [DW-1:0] rdd(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  // checker
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    reset      = 1'b0;
    rd_addr    = '0;
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    issue_en   = 1'b0;
    issue_addr = '0;
    flush      = 1'b0;

    // reset state
    set_rd(0, 5'd5);
    #2;
    check("rst_rd_data", rdd(0), 32'h0);
    check("rst_rd_busy", 32'(rd_busy), 32'h0);
    check("rst_busy_any", 32'(busy_any), 32'h0);
    #10 reset = 1'b1;
    tick();

    // asynchronous reset mid-cycle
    set_wr(0, 5'd5, 32'hDEADBEEF);
    set_issue(5'd6);
    tick();
    idle();
    #1;
    check("wr_r5", rdd(0), 32'hDEADBEEF);
    check("busy_any_set", 32'(busy_any), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_r5", rdd(0), 32'h0);
    check("async_rst_busy_any", 32'(busy_any), 32'h0);
    #1 reset = 1'b1;
    tick();
    check("post_rst_r5", rdd(0), 32'h0);

    // write collision: port 1 wins
    set_wr(0, 5'd7, 32'h1111);
    set_wr(1, 5'd7, 32'h2222);
    set_rd(1, 5'd7);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("coll_same_cycle", rdd(1), 32'h2222);
`else
    check("coll_same_cycle", rdd(1), 32'h0);
`endif
    tick();
    idle();
    #1;
    check("coll_r7", rdd(1), 32'h2222);

    // two ports, distinct addresses
    set_wr(0, 5'd11, 32'hAAAA);
    set_wr(1, 5'd12, 32'hBBBB);
    tick();
    idle();
    set_rd(0, 5'd11);
    set_rd(1, 5'd12);
    #1;
    check("dual_r11", rdd(0), 32'hAAAA);
    check("dual_r12", rdd(1), 32'hBBBB);

    // zero register
    set_wr(1, 5'd0, 32'hFFFFFFFF);
    set_issue(5'd0);
    set_rd(0, 5'd0);
    #1;
    check("zero_same_cycle", rdd(0), 32'h0);
    tick();
    idle();
    #1;
    check("zero_data", rdd(0), 32'h0);
    check("zero_busy", 32'(rd_busy[0]), 32'h0);
    check("zero_busy_any", 32'(busy_any), 32'h0);

    // scoreboard: issue, then write two cycles later
    set_issue(5'd3);
    set_rd(0, 5'd3);
    set_rd(1, 5'd3);
    tick();
    idle();
    #1;
    check("sb_busy_p0", 32'(rd_busy[0]), 32'h1);
    check("sb_busy_p1", 32'(rd_busy[1]), 32'h1);
    check("sb_busy_any", 32'(busy_any), 32'h1);
    tick();
    check("sb_still_busy", 32'(rd_busy[0]), 32'h1);
    set_wr(0, 5'd3, 32'h3333);
    tick();
    idle();
    #1;
    check("sb_cleared", 32'(rd_busy[0]), 32'h0);
    check("sb_r3_data", rdd(1), 32'h3333);
    // issue and write same register in one cycle: new producer wins
    set_issue(5'd3);
    set_wr(1, 5'd3, 32'h3434);
    tick();
    idle();
    #1;
    check("sb_issue_wr_busy", 32'(rd_busy[1]), 32'h1);
    check("sb_issue_wr_data", rdd(0), 32'h3434);
    set_wr(0, 5'd3, 32'h3535);
    tick();
    idle();
    #1;
    check("sb_clear2", 32'(rd_busy[0]), 32'h0);

    // flush: drops busy bits and same-cycle issue, keeps write
    set_issue(5'd4);
    tick();
    set_issue(5'd9);
    tick();
    idle();
    #1;
    check("fl_busy_any_pre", 32'(busy_any), 32'h1);
    flush = 1'b1;
    set_issue(5'd10);
    set_wr(0, 5'd13, 32'h1313);
    tick();
    idle();
    set_rd(0, 5'd4);
    set_rd(1, 5'd9);
    #1;
    check("fl_r4_busy", 32'(rd_busy[0]), 32'h0);
    check("fl_r9_busy", 32'(rd_busy[1]), 32'h0);
    check("fl_busy_any", 32'(busy_any), 32'h0);
    set_rd(0, 5'd10);
    set_rd(1, 5'd13);
    #1;
    check("fl_r10_busy", 32'(rd_busy[0]), 32'h0);
    check("fl_wr_kept", rdd(1), 32'h1313);

    // bypass: r8 busy with old value, then written while read
    set_wr(0, 5'd8, 32'h88);
    set_issue(5'd8);
    tick();
    idle();
    set_wr(1, 5'd8, 32'hCAFEF00D);
    set_rd(0, 5'd8);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_data", rdd(0), 32'hCAFEF00D);
    check("byp_busy", 32'(rd_busy[0]), 32'h0);
`else
    check("byp_data", rdd(0), 32'h88);
    check("byp_busy", 32'(rd_busy[0]), 32'h1);
`endif
    check("byp_busy_any", 32'(busy_any), 32'h1);
    tick();
    idle();
    #1;
    check("byp_next_data", rdd(0), 32'hCAFEF00D);
    check("byp_next_busy", 32'(rd_busy[0]), 32'h0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
